// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder and its byte-lane merge helper.
package dm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic int word_idx_w(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Merges store data into an existing word lane by lane under a 4-bit byte enable.
module dm_byte_merge
    import dm_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        if (be == BE_WORD) begin
            merged = wdata;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    merged[8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Word-addressed data-memory responder with programmable wait states, byte-enabled
// stores and error reporting for misaligned, empty-enable or out-of-range accesses.
module dm_responder
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int          IW    = word_idx_w(DEPTH_WORDS);
    localparam int          CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    state_t        state;
    logic [CW-1:0] cnt;

    logic          we_q;
    logic [31:0]   addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          cur_we;
    logic [31:0]   cur_addr;
    logic [3:0]    cur_be;
    logic [31:0]   cur_off;
    logic [IW-1:0] cur_idx;
    logic          cur_err;
    logic [31:0]   rd_word;
    logic [31:0]   resp_data;
    logic [31:0]   merged;

    // In IDLE the live inputs are the transaction (zero-wait case responds
    // straight from them); in every other state only the latched copy counts.
    always_comb begin
        cur_we   = we_q;
        cur_addr = addr_q;
        cur_be   = be_q;
        if (state == S_IDLE) begin
            cur_we   = we;
            cur_addr = addr;
            cur_be   = be;
        end
    end

    assign cur_off   = cur_addr - BASE_ADDR;
    assign cur_idx   = IW'(cur_off >> 2);
    assign cur_err   = (cur_addr[1:0] != 2'b00)
                    || (cur_be == 4'b0000)
                    || (cur_addr < BASE_ADDR)
                    || ({1'b0, cur_addr} >= LIMIT);
    assign rd_word   = mem[cur_idx];
    assign resp_data = (cur_err || cur_we) ? 32'h0 : rd_word;

    dm_byte_merge u_merge (
        .old_word (rd_word),
        .wdata    (wdata_q),
        .be       (be_q),
        .merged   (merged)
    );

    // Transaction copy: captured once at acceptance, never reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            we_q    <= we;
            addr_q  <= addr;
            be_q    <= be;
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            ready <= 1'b0;
            rdata <= 32'h0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        busy <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                            ready <= 1'b1;
                            err   <= cur_err;
                            rdata <= resp_data;
                        end else begin
                            cnt   <= CW'(WAIT_CYCLES - 1);
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_RESP;
                        ready <= 1'b1;
                        err   <= cur_err;
                        rdata <= resp_data;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                    err   <= 1'b0;
                    rdata <= 32'h0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stores commit on the edge leaving RESP, so a reset seen in WAIT/RESP drops them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (state == S_RESP && we_q && !err) begin
            mem[cur_idx] <= merged;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a two-wait-state instance and a zero-wait instance.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_a, we_a, ready_a, err_a, busy_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [3:0]  be_a;

    logic        req_b, we_b, ready_b, err_b, busy_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [3:0]  be_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        e;
    int          lat;
    logic        seen;

    logic        b_we   [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] b_addr [3] = '{32'h4, 32'h4, 32'h40};
    logic [31:0] b_wd   [3] = '{32'hA5A5_A5A5, 32'h0, 32'h0};
    int          b_cyc  [3] = '{-1, -1, -1};
    logic [31:0] b_rd   [3];
    logic        b_err  [3];
    int          b_idx;
    int          b_nready;

    dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a), .be(be_a),
        .wdata(wdata_a), .ready(ready_a), .rdata(rdata_a), .err(err_a), .busy(busy_a)
    );

    dm_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .be(be_b),
        .wdata(wdata_b), .ready(ready_b), .rdata(rdata_b), .err(err_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction on instance A; lat is the index of the cycle after acceptance
    // in which ready is seen (-1 if it never appears).
    task automatic txn_a(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input bit churn,
                         output logic [31:0] rdo, output logic eo, output int lato);
        req_a = 1'b1; we_a = w; addr_a = a; be_a = b; wdata_a = d;
        rdo = 32'h0; eo = 1'b0; lato = -1;
        @(posedge clk); #1;
        for (int k = 1; k <= 16; k++) begin
            if (ready_a) begin
                rdo = rdata_a; eo = err_a; lato = k;
                break;
            end
            if (churn) begin
                addr_a  = addr_a + 32'h1001;
                wdata_a = $urandom;
                be_a    = be_a ^ 4'hF;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_a = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_a = 1'b0; we_a = 1'b0; addr_a = 32'h0; be_a = 4'h0; wdata_a = 32'h0;
        req_b = 1'b0; we_b = 1'b0; addr_b = 32'h0; be_b = 4'h0; wdata_b = 32'h0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_ready_a", 32'(ready_a), 32'h0);
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_err_a",   32'(err_a), 32'h0);
        check("rst_busy_a",  32'(busy_a), 32'h0);
        check("rst_ready_b", 32'(ready_b), 32'h0);
        check("rst_busy_b",  32'(busy_b), 32'h0);

        // store then load back
        txn_a(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, rd, e, lat);
        check("sw_latency", 32'(lat), 32'd3);
        check("sw_err",     32'(e), 32'h0);
        check("sw_rdata",   rd, 32'h0);
        txn_a(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, rd, e, lat);
        check("lw_latency", 32'(lat), 32'd3);
        check("lw_rdata",   rd, 32'hDEAD_BEEF);
        check("lw_err",     32'(e), 32'h0);

        // partial-lane store
        txn_a(1'b1, 32'h20, 4'hF, 32'h1122_3344, 1'b0, rd, e, lat);
        txn_a(1'b1, 32'h20, 4'b0100, 32'h00AA_0000, 1'b0, rd, e, lat);
        check("be_store_err", 32'(e), 32'h0);
        txn_a(1'b0, 32'h20, 4'b0001, 32'h0, 1'b0, rd, e, lat);
        check("be_merge_rdata", rd, 32'h11AA_3344);

        // error responses
        txn_a(1'b1, 32'h22, 4'hF, 32'h5555_5555, 1'b0, rd, e, lat);
        check("misalign_err",   32'(e), 32'h1);
        check("misalign_rdata", rd, 32'h0);
        check("misalign_lat",   32'(lat), 32'd3);
        txn_a(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, rd, e, lat);
        check("misalign_nowrite", rd, 32'h11AA_3344);
        txn_a(1'b1, 32'd4096, 4'hF, 32'h7777_7777, 1'b0, rd, e, lat);
        check("oob_err", 32'(e), 32'h1);
        txn_a(1'b0, 32'd4092, 4'hF, 32'h0, 1'b0, rd, e, lat);
        check("last_word_err",   32'(e), 32'h0);
        check("last_word_rdata", rd, 32'h0);
        txn_a(1'b0, 32'h20, 4'h0, 32'h0, 1'b0, rd, e, lat);
        check("be0_err",   32'(e), 32'h1);
        check("be0_rdata", rd, 32'h0);

        // reset during WAIT aborts the store
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h30; be_a = 4'hF; wdata_a = 32'hCAFE_F00D;
        @(posedge clk); #1;
        check("mid_busy", 32'(busy_a), 32'h1);
        req_a = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_ready_after_rst", 32'(ready_a), 32'h0);
        check("mid_busy_after_rst",  32'(busy_a), 32'h0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ready_a) seen = 1'b1;
        end
        check("mid_no_ready", 32'(seen), 32'h0);
        txn_a(1'b0, 32'h30, 4'hF, 32'h0, 1'b0, rd, e, lat);
        check("mid_lw_rdata", rd, 32'h0);
        check("mid_lw_lat",   32'(lat), 32'd3);
        txn_a(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, rd, e, lat);
        check("rst_cleared_mem", rd, 32'h0);

        // inputs churn during WAIT; req held through RESP
        txn_a(1'b1, 32'h40, 4'hF, 32'h1234_5678, 1'b1, rd, e, lat);
        check("churn_err", 32'(e), 32'h0);
        check("churn_lat", 32'(lat), 32'd3);
        check("churn_busy_after",  32'(busy_a), 32'h0);
        check("churn_ready_after", 32'(ready_a), 32'h0);
        @(posedge clk); #1;
        check("churn_no_second", 32'(busy_a), 32'h0);
        txn_a(1'b0, 32'h40, 4'hF, 32'h0, 1'b0, rd, e, lat);
        check("churn_lw_rdata", rd, 32'h1234_5678);
        txn_a(1'b0, 32'h44, 4'hF, 32'h0, 1'b0, rd, e, lat);
        check("churn_neighbour", rd, 32'h0);

        // zero-wait instance: single load
        req_b = 1'b1; we_b = 1'b0; addr_b = 32'h0; be_b = 4'hF; wdata_b = 32'h0;
        @(posedge clk); #1;
        check("b_lat1_ready", 32'(ready_b), 32'h1);
        check("b_lat1_rdata", rdata_b, 32'h0);
        check("b_lat1_err",   32'(err_b), 32'h0);
        check("b_lat1_busy",  32'(busy_b), 32'h1);
        @(posedge clk); #1;
        req_b = 1'b0;
        check("b_after_ready", 32'(ready_b), 32'h0);
        check("b_after_busy",  32'(busy_b), 32'h0);

        // zero-wait instance: back-to-back store, load, out-of-range load
        b_idx = 0; b_nready = 0;
        req_b = 1'b1; we_b = b_we[0]; addr_b = b_addr[0]; be_b = 4'hF; wdata_b = b_wd[0];
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (ready_b) begin
                b_nready++;
                if (b_idx < 3) begin
                    b_cyc[b_idx] = c; b_rd[b_idx] = rdata_b; b_err[b_idx] = err_b;
                    b_idx++;
                    if (b_idx < 3) begin
                        we_b = b_we[b_idx]; addr_b = b_addr[b_idx]; wdata_b = b_wd[b_idx];
                    end else begin
                        req_b = 1'b0;
                    end
                end
            end
        end
        req_b = 1'b0;
        check("b2b_first_cycle", 32'(b_cyc[0]), 32'd1);
        check("b2b_gap01", 32'(b_cyc[1] - b_cyc[0]), 32'd2);
        check("b2b_gap12", 32'(b_cyc[2] - b_cyc[1]), 32'd2);
        check("b2b_nready", 32'(b_nready), 32'd3);
        check("b2b_store_rdata", b_rd[0], 32'h0);
        check("b2b_load_rdata",  b_rd[1], 32'hA5A5_A5A5);
        check("b2b_load_err",    32'(b_err[1]), 32'h0);
        check("b2b_oob_err",     32'(b_err[2]), 32'h1);
        check("b2b_oob_rdata",   b_rd[2], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder on the CPU's load/store request interface; the CPU core is the initiator.
- Accepts one word-addressed request at a time and inserts a programmable number of wait states.
- Commits stores with byte enables, returns load data and flags bad accesses.
- Lets the team's top-level bench exercise a non-zero-latency memory behind the mips core.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored.
- WAIT_CYCLES, 2, wait states between acceptance and response; 0 is legal.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request valid; held by the initiator until it samples ready=1.
- we  input  1  1 = store, 0 = load.
- addr  input  32  byte address; word index = (addr-BASE_ADDR)>>2.
- be  input  4  byte-lane enables; be[i] enables bits 8i+7:8i.
- wdata  input  32  store data, lane-aligned.
- ready  output  1  one-cycle response strobe.
- rdata  output  32  load data; valid only while ready=1.
- err  output  1  response error flag; valid only while ready=1.
- busy  output  1  high while a request is in flight (WAIT or RESP).

Behaviour:
- Reset, checked only at the clock edge:
  - ready=0, rdata=0, err=0, busy=0, state=IDLE, counter=0.
  - All DEPTH_WORDS words cleared to 0.
  - Reset wins over every other event in the same cycle.
- States are IDLE, WAIT and RESP.
- IDLE:
  - req=1 latches we, addr, be and wdata, and sets busy=1.
  - WAIT_CYCLES>0: counter=WAIT_CYCLES-1, go to WAIT.
  - WAIT_CYCLES=0: go to RESP.
  - req=0: stay in IDLE.
- WAIT:
  - counter=0 goes to RESP; otherwise counter decrements.
  - req and other input changes are ignored; only the latched copy is used.
- RESP:
  - Lasts exactly one cycle: ready=1, then unconditionally back to IDLE with busy=0.
  - The initiator drops req on the edge where it samples ready. req still high in RESP is ignored.
- Latency: ready rises WAIT_CYCLES+1 cycles after the edge that accepted req.
- Error rule: err=1 when any of the following holds.
  - addr[1:0]!=0.
  - be==0.
  - addr<BASE_ADDR.
  - addr>=BASE_ADDR+4*DEPTH_WORDS.
- Error response: no memory write, rdata=0, err=1, ready=1.
- Store without error:
  - Lanes with be[i]=1 take wdata; other lanes are kept.
  - Written on the edge that leaves RESP. A load in the next transaction returns the new value.
  - rdata=0 during a store response.
- Load without error:
  - rdata is the full 32-bit word, independent of be.
  - Lane extraction and sign extension are done by the core.
- Reset during WAIT or RESP aborts the transaction with no write. The next request after reset is serviced normally.
- ready, rdata and err are registered outputs. There is no combinational path from inputs to outputs.
- busy is high from the cycle after acceptance through the RESP cycle inclusive.

Decomposition:
- Shared package dm_pkg holds:
  - state encoding localparams: S_IDLE=2'd0, S_WAIT=2'd1, S_RESP=2'd2.
  - BE_WORD=4'b1111.
  - word-index helper width = $clog2(DEPTH_WORDS).
- One sub-module is natural: dm_byte_merge.
  - Purely combinational.
  - Inputs: old word, wdata, be. Output: merged word.
  - Reused later by the cache write path.
- FSM, counter and storage stay in dm_responder.

Test Plan:
1. Reset then sw: reset 1 cycle; req, we=1, addr=0x10, be=1111, wdata=0xDEADBEEF at WAIT_CYCLES=2 -> ready exactly 3 cycles after acceptance, err=0, rdata=0. Follow-up lw at 0x10 -> rdata=0xDEADBEEF.
2. Byte enables: store 0x11223344 to 0x20, then be=0100, wdata=0x00AA0000 -> load at 0x20 returns 0x11AA3344.
3. Errors:
   - addr=0x22 -> err=1, rdata=0, and the word at 0x20 is unchanged.
   - addr=4*DEPTH_WORDS -> err=1.
   - be=0000 -> err=1.
4. WAIT_CYCLES=0 instance: lw at 0x0 after reset -> ready on the cycle after acceptance, rdata=0. Back-to-back requests -> one ready per 2 cycles.
5. Mid-transaction: assert reset during WAIT of a store of 0xCAFEF00D to 0x30 -> no ready pulse; after reset a load at 0x30 returns 0.
6. Input churn: change addr and wdata every cycle during WAIT -> the response and write use the values latched at acceptance. req held high through RESP does not start a second transaction.
